// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences each instruction through
// fetch, decode, execute, memory and write-back, and drives the datapath
// enables, mux selects and the ALU class code for the ALU control decoder.
module mips_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_code,
    output logic [1:0] pc_source,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_LWB    = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    state_t state_q;
    state_t state_d;

    // Next-state selection; opcode only matters in ID and MEMADR, where the
    // instruction register cannot change because ir_write is low.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:     state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXEC;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDIU: state_d = S_IEXEC;
                    default:  state_d = S_IF;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_LWB : S_MEMRD;
            S_LWB:    state_d = S_IF;
            S_MEMWR:  state_d = mem_ready ? S_IF : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_IF;
            S_BRANCH: state_d = S_IF;
            S_JUMP:   state_d = S_IF;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    // State register; reset aborts any instruction and returns to fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode; only the fetch-cycle IR/PC loads follow
    // mem_ready, and everything is held low while reset is asserted.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_code      = 2'b00;
        pc_source     = 2'b00;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID: begin
                    alu_src_b = 2'b11;
                end
                S_MEMADR, S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_LWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_code  = 2'b10;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_code      = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Testbench for mips_control_fsm: directed instruction sequences followed
// by randomized opcodes and memory wait patterns, checked every cycle
// against a per-instruction route model.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_code, pc_source;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected state plus the remaining states of the
    // current instruction, decided from the opcode at decode time.
    int exp_st = 0;
    int route_q[$];

    mips_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_code      (alu_code),
        .pc_source     (pc_source),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dut_out();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_code,
                pc_source};
    endfunction

    // Output table: {pcw,pcwc,iord,mrd,mwr,irw,m2r,rdst,rwr,asa,asb,acode,psrc}
    function automatic logic [15:0] ref_out(int st, logic mr);
        case (st)
            0:       return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
            1:       return {9'b0, 1'b0, 2'b11, 2'b00, 2'b00};
            2, 10:   return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            3:       return {2'b00, 1'b1, 1'b1, 12'b0};
            4:       return {6'b0, 1'b1, 1'b0, 1'b1, 7'b0};
            5:       return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
            6:       return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            7:       return {7'b0, 1'b1, 1'b1, 7'b0};
            8:       return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            9:       return {1'b1, 13'b0, 2'b10};
            11:      return {8'b0, 1'b1, 7'b0};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic [5:0] op, input logic mr);
        int nxt;
        nxt = 0;
        if (exp_st == 0) begin
            nxt = mr ? 1 : 0;
        end else begin
            if (exp_st == 1) begin
                route_q.delete();
                case (op)
                    6'b100011: route_q = '{2, 3, 4};
                    6'b101011: route_q = '{2, 5};
                    6'b000000: route_q = '{6, 7};
                    6'b000100: route_q = '{8};
                    6'b000010: route_q = '{9};
                    6'b001001: route_q = '{10, 11};
                    default:   route_q.delete();
                endcase
            end
            if ((exp_st == 3 || exp_st == 5) && !mr) begin
                nxt = exp_st;
            end else if (route_q.size() > 0) begin
                nxt = route_q.pop_front();
            end else begin
                nxt = 0;
            end
        end
        exp_st = nxt;
    endtask

    // One clock cycle: drive inputs just after the falling edge, compare,
    // then update the model and wait for the next falling edge.
    task automatic step(input logic [5:0] op, input logic mr);
        opcode    = op;
        mem_ready = mr;
        #1;
        chk($sformatf("state@%0d", exp_st), {12'b0, state}, 16'(exp_st));
        chk($sformatf("outs@%0d", exp_st), dut_out(), ref_out(exp_st, mr));
        model_step(op, mr);
        @(negedge clk);
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0:       return 6'b000000;
            1:       return 6'b100011;
            2:       return 6'b101011;
            3:       return 6'b000100;
            4:       return 6'b000010;
            5:       return 6'b001001;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        logic [5:0] cur_op;
        rst       = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b1;

        // Reset held in IF with mem_ready high: everything low.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", {12'b0, state}, 16'h0000);
        chk("rst_outs", dut_out(), 16'h0000);
        rst = 1'b0;

        // lw with no waits: 0,1,2,3,4,0
        repeat (5) step(6'b100011, 1'b1);
        // R-type: 0,1,6,7
        repeat (4) step(6'b000000, 1'b1);
        // beq then j
        repeat (3) step(6'b000100, 1'b1);
        repeat (3) step(6'b000010, 1'b1);
        // sw with three wait cycles in MEMWR
        repeat (3) step(6'b101011, 1'b1);
        repeat (3) step(6'b101011, 1'b0);
        step(6'b101011, 1'b1);
        // addiu, then an unknown opcode (0,1,0)
        repeat (4) step(6'b001001, 1'b1);
        repeat (2) step(6'b111111, 1'b1);
        // fetch wait cycles
        repeat (2) step(6'b000000, 1'b0);
        repeat (4) step(6'b000000, 1'b1);

        // lw interrupted by reset while waiting in MEMRD
        repeat (3) step(6'b100011, 1'b1);
        step(6'b100011, 1'b0);
        mem_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_state", {12'b0, state}, 16'h0000);
        chk("midrst_outs", dut_out(), 16'h0000);
        exp_st = 0;
        route_q.delete();
        @(negedge clk);
        #1;
        chk("midrst_hold", dut_out(), 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        // The edge above fetched with mem_ready=1 -> now in decode.
        exp_st = 1;
        step(6'b111111, 1'b1);

        // Randomized instructions and memory waits.
        cur_op = pick_op();
        for (int i = 0; i < 400; i++) begin
            if (exp_st == 0) cur_op = pick_op();
            step(cur_op, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
